// File: rtl/uart_frame_ctrl_if.sv
// Bundle between the word assembler, the frame controller, the image RAM
// write port and the recognition core. The controller uses the slave view;
// the environment feeding words and watching the RAM uses the master view.
interface uart_frame_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]       word_data;
    logic              word_valid;
    logic              infer_busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              infer_start;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    modport master (
        output word_data,
        output word_valid,
        output infer_busy,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        input  infer_start,
        input  frame_err,
        input  err_code,
        input  busy
    );

    modport slave (
        input  word_data,
        input  word_valid,
        input  infer_busy,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        output infer_start,
        output frame_err,
        output err_code,
        output busy
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Frame controller: hunts for a header word, streams a fixed number of
// payload words into the image RAM, verifies the trailing checksum and
// starts the recognition core once it is idle. Bad or stalled frames are
// dropped with an error pulse and a sticky error code.
module uart_frame_ctrl #(
    parameter logic [31:0] HEADER      = 32'hA55A_0001,
    parameter int          WORDS       = 196,
    parameter int          ADDR_W      = 8,
    parameter int          TIMEOUT_CYC = 5_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    uart_frame_ctrl_if.slave   bus
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        WAIT_INF,
        START
    } state_t;

    state_t            state_q, state_d;
    logic              vld_sync_q, vld_sync_d;
    logic              vld_dly_q, vld_dly_d;
    logic              busy_sync_q, busy_sync_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       sum_q, sum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              word_evt;
    logic              tmo_hit;

    // A held word_valid level produces exactly one event on its rising edge.
    assign word_evt = vld_sync_q & ~vld_dly_q;
    assign tmo_hit  = (tmo_q == TMO_LAST);

    // State register and all datapath flops; reset aborts any frame silently.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            vld_sync_q  <= 1'b0;
            vld_dly_q   <= 1'b0;
            busy_sync_q <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            vld_sync_q  <= vld_sync_d;
            vld_dly_q   <= vld_dly_d;
            busy_sync_q <= busy_sync_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state, RAM write, checksum, timeout and error decisions.
    always_comb begin
        state_d     = state_q;
        vld_sync_d  = bus.word_valid;
        vld_dly_d   = vld_sync_q;
        busy_sync_d = bus.infer_busy;
        idx_d       = idx_q;
        sum_d       = sum_q;
        tmo_d       = '0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        if ((state_q == PAYLOAD) || (state_q == CHECK)) begin
            tmo_d = word_evt ? '0 : (tmo_q + TMO_W'(1));
        end

        case (state_q)
            IDLE: begin
                if (word_evt && (bus.word_data == HEADER)) begin
                    state_d    = PAYLOAD;
                    idx_d      = '0;
                    sum_d      = '0;
                    err_code_d = 2'd0;
                end
            end
            PAYLOAD: begin
                if (word_evt) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q[ADDR_W-1:0];
                    ram_wdata_d = bus.word_data;
                    sum_d       = sum_q + bus.word_data;
                    idx_d       = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                    end
                end else if (tmo_hit) begin
                    err_code_d  = 2'd1;
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            CHECK: begin
                if (word_evt) begin
                    if (bus.word_data == sum_q) begin
                        state_d = WAIT_INF;
                    end else begin
                        err_code_d  = 2'd2;
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmo_hit) begin
                    err_code_d  = 2'd1;
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_INF: begin
                if (word_evt) begin
                    err_code_d  = 2'd3;
                    frame_err_d = 1'b1;
                end else if (!busy_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.infer_start = (state_q == START);
    assign bus.frame_err   = frame_err_q;
    assign bus.err_code    = err_code_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus randomized
// frames, compared against a word-stream reference model.
module tb_uart_frame_ctrl;

   localparam logic [31:0] HDR    = 32'hA55A_0001;
   localparam int          WORDS  = 4;
   localparam int          ADDR_W = 8;
   localparam int          TMO    = 100;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;

   uart_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   uart_frame_ctrl #(
      .HEADER(HDR),
      .WORDS(WORDS),
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus(bus)
   );

   int testsRun = 0;
   int testsFailed = 0;
   int cycle = 0;
   int lastRiseCyc = 0;

   wr_t obsWr[$];
   int  obsStarts = 0;
   int  obsErrs = 0;
   int  lastStartCyc = -1;
   int  lastErrCyc = -1;

   wr_t         expWr[$];
   int          expStarts = 0;
   int          expErrs = 0;
   logic [1:0]  mCode = 2'd0;

   // Free-running clock
   always #5 sys_clk = ~sys_clk;

   // Cycle counter advanced on every active edge
   initial begin
      forever begin
         @(posedge sys_clk);
         cycle++;
      end
   end

   // Monitor sampling DUT outputs on the inactive edge
   initial begin
      forever begin
         @(negedge sys_clk);
         if (bus.ram_we === 1'b1) obsWr.push_back('{int'(bus.ram_addr), bus.ram_wdata, cycle});
         if (bus.infer_start === 1'b1) begin
            obsStarts++;
            lastStartCyc = cycle;
         end
         if (bus.frame_err === 1'b1) begin
            obsErrs++;
            lastErrCyc = cycle;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] w, input int hold, input int gap);
      @(negedge sys_clk);
      bus.word_data  = w;
      bus.word_valid = 1'b1;
      lastRiseCyc    = cycle;
      repeat (hold) @(negedge sys_clk);
      bus.word_valid = 1'b0;
      repeat (gap) @(negedge sys_clk);
   endtask

   task automatic sendWords(input logic [31:0] ws[$]);
      foreach (ws[i]) applyStimulus(ws[i], $urandom_range(1, 3), $urandom_range(0, 3));
   endtask

   task automatic clearObs();
      obsWr.delete();
      expWr.delete();
      obsStarts = 0;
      obsErrs = 0;
      expStarts = 0;
      expErrs = 0;
      lastStartCyc = -1;
      lastErrCyc = -1;
   endtask

   // Word-level model: header hunt, WORDS payload writes, then checksum verdict
   task automatic modelStream(input logic [31:0] ws[$]);
      int mode = 0;
      int n = 0;
      logic [31:0] s = 32'd0;
      foreach (ws[i]) begin
         case (mode)
            0: if (ws[i] == HDR) begin
                  mode = 1;
                  n = 0;
                  s = 32'd0;
                  mCode = 2'd0;
               end
            1: begin
                  expWr.push_back('{n, ws[i], 0});
                  s += ws[i];
                  n++;
                  if (n == WORDS) mode = 2;
               end
            default: begin
                  if (ws[i] == s) expStarts++;
                  else begin
                     expErrs++;
                     mCode = 2'd2;
                  end
                  mode = 0;
               end
         endcase
      end
   endtask

   task automatic buildFrame(input bit bad, output logic [31:0] ws[$]);
      logic [31:0] s = 32'd0;
      logic [31:0] d;
      ws.delete();
      ws.push_back(HDR);
      for (int i = 0; i < WORDS; i++) begin
         d = $urandom;
         ws.push_back(d);
         s += d;
      end
      ws.push_back(bad ? (s + 32'($urandom_range(1, 255))) : s);
   endtask

   task automatic compareObs(input string tag, input logic expBusy);
      checkOutput({tag, "_wrcnt"}, 32'(obsWr.size()), 32'(expWr.size()));
      for (int i = 0; i < expWr.size() && i < obsWr.size(); i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), 32'(obsWr[i].addr), 32'(expWr[i].addr));
         checkOutput($sformatf("%s_data%0d", tag, i), obsWr[i].data, expWr[i].data);
      end
      checkOutput({tag, "_starts"}, 32'(obsStarts), 32'(expStarts));
      checkOutput({tag, "_errs"}, 32'(obsErrs), 32'(expErrs));
      checkOutput({tag, "_errcode"}, 32'(bus.err_code), 32'(mCode));
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(expBusy));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
      checkOutput({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
      checkOutput({tag, "_ram_wdata"}, bus.ram_wdata, 32'd0);
      checkOutput({tag, "_start"}, 32'(bus.infer_start), 32'd0);
      checkOutput({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
      checkOutput({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   // Main sequence of directed and randomized scenarios
   initial begin
      logic [31:0] ws[$];
      int riseW1, riseSum, fallCyc, diff;

      bus.word_data  = 32'd0;
      bus.word_valid = 1'b0;
      bus.infer_busy = 1'b0;

      repeat (3) @(negedge sys_clk);
      checkAllZero("reset");
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      // Nominal frame with latency checks
      clearObs();
      applyStimulus(HDR, 2, 1);
      applyStimulus(32'd1, 2, 1);
      riseW1 = lastRiseCyc;
      applyStimulus(32'd2, 1, 0);
      applyStimulus(32'd3, 3, 2);
      applyStimulus(32'd4, 1, 1);
      applyStimulus(32'd10, 1, 0);
      riseSum = lastRiseCyc;
      repeat (8) @(negedge sys_clk);
      modelStream('{HDR, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10});
      compareObs("nominal", 1'b0);
      diff = (obsWr.size() > 0) ? (obsWr[0].cyc - riseW1) : -1;
      checkOutput("nominal_wr_latency", 32'(diff), 32'd2);
      checkOutput("nominal_start_latency", 32'(lastStartCyc - riseSum), 32'd3);

      // Bad checksum
      clearObs();
      sendWords('{HDR, 32'd1, 32'd2, 32'd3, 32'd4, 32'd11});
      repeat (6) @(negedge sys_clk);
      modelStream('{HDR, 32'd1, 32'd2, 32'd3, 32'd4, 32'd11});
      compareObs("badsum", 1'b0);

      // Timeout after two payload words
      clearObs();
      sendWords('{HDR, 32'd1, 32'd2});
      repeat (150) @(negedge sys_clk);
      modelStream('{HDR, 32'd1, 32'd2});
      expErrs = 1;
      mCode = 2'd1;
      compareObs("timeout", 1'b0);
      diff = (obsWr.size() >= 2) ? (lastErrCyc - obsWr[1].cyc) : -1;
      checkOutput("timeout_gap", 32'(diff), 32'd100);

      // Noise in idle, then a header held high for 50 cycles
      clearObs();
      applyStimulus(32'h0000_1234, 2, 2);
      applyStimulus(32'hFFFF_FFFF, 2, 2);
      applyStimulus(HDR, 50, 2);
      checkOutput("noise_no_writes", 32'(obsWr.size()), 32'd0);
      checkOutput("noise_hdr_busy", 32'(bus.busy), 32'd1);
      checkOutput("noise_errs", 32'(obsErrs), 32'd0);
      buildFrame(1'b0, ws);
      void'(ws.pop_front());
      sendWords(ws);
      repeat (6) @(negedge sys_clk);
      ws.push_front(HDR);
      ws.push_front(32'hFFFF_FFFF);
      ws.push_front(32'h0000_1234);
      modelStream(ws);
      compareObs("noise", 1'b0);

      // Busy core with one extra word during the wait
      clearObs();
      @(negedge sys_clk);
      bus.infer_busy = 1'b1;
      buildFrame(1'b0, ws);
      sendWords(ws);
      repeat (8) @(negedge sys_clk);
      applyStimulus(32'h0000_0055, 1, 1);
      repeat (15) @(negedge sys_clk);
      checkOutput("busycore_no_start_yet", 32'(obsStarts), 32'd0);
      @(negedge sys_clk);
      bus.infer_busy = 1'b0;
      fallCyc = cycle;
      repeat (8) @(negedge sys_clk);
      modelStream(ws);
      expErrs = 1;
      mCode = 2'd3;
      compareObs("busycore", 1'b0);
      checkOutput("busycore_start_delay", 32'(lastStartCyc - fallCyc), 32'd2);

      // Reset in the middle of a frame, then a clean frame from address 0
      clearObs();
      sendWords('{HDR, 32'h1111_2222, 32'hDEAD_BEEF});
      checkOutput("midrst_busy_before", 32'(bus.busy), 32'd1);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      checkAllZero("midrst");
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      mCode = 2'd0;
      repeat (2) @(negedge sys_clk);
      clearObs();
      buildFrame(1'b0, ws);
      sendWords(ws);
      repeat (6) @(negedge sys_clk);
      modelStream(ws);
      compareObs("postrst", 1'b0);

      // Randomized frames with noise and occasional bad checksums
      for (int it = 0; it < 8; it++) begin
         logic [31:0] full[$];
         logic [31:0] nz;
         clearObs();
         full.delete();
         for (int k = 0; k < $urandom_range(0, 2); k++) begin
            nz = $urandom;
            if (nz == HDR) nz = nz ^ 32'd1;
            full.push_back(nz);
         end
         buildFrame($urandom_range(0, 3) == 0, ws);
         foreach (ws[j]) full.push_back(ws[j]);
         sendWords(full);
         repeat (6) @(negedge sys_clk);
         modelStream(full);
         compareObs($sformatf("rand%0d", it), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
